// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART frame-format constants and frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam logic [1:0] DB5 = 2'b00;
   localparam logic [1:0] DB6 = 2'b01;
   localparam logic [1:0] DB7 = 2'b10;
   localparam logic [1:0] DB8 = 2'b11;

   localparam int MIN_FRAME_BITS = 7;
   localparam int MAX_FRAME_BITS = 12;

   localparam int UART_DEF_DIV = 5208;
   localparam int UART_MIN_DIV = 2;

   // Slots: start + (5 + data_bits) data + optional parity + (1 + stop2) stop.
   function automatic logic [3:0] frame_len(input logic [1:0] data_bits,
                                            input logic       parity_en,
                                            input logic       stop2);
      frame_len = 4'd7 + {2'b00, data_bits} + {3'b000, parity_en} + {3'b000, stop2};
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bps_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_bps_gen
// Description : Programmable UART bit-timing generator with mid/end strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bps_gen
   import uart_pkg::*;
#(
   parameter int DIV_W   = 16,
   parameter int DEF_DIV = UART_DEF_DIV,
   parameter int MIN_DIV = UART_MIN_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [DIV_W-1:0] div,
   input  logic [1:0]       data_bits,
   input  logic             parity_en,
   input  logic             stop2,
   output logic             busy,
   output logic             bit_mid,
   output logic             bit_end,
   output logic [3:0]       bit_idx,
   output logic             frame_done
);

   // A divisor below 2 would put the mid point at or before the bit start.
   localparam int               MIN_EFF = (MIN_DIV < 2) ? 2 : MIN_DIV;
   localparam logic [DIV_W-1:0] C_DEF   = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0] C_MIN   = DIV_W'(MIN_EFF);
   localparam logic [DIV_W-1:0] C_ONE   = DIV_W'(1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] dvm1_q, dvm1_d;
   logic [DIV_W-1:0] hm1_q, hm1_d;
   logic [3:0]       last_q, last_d;
   logic [3:0]       idx_q, idx_d;
   logic             mid_q, mid_d;
   logic             end_q, end_d;
   logic             done_q, done_d;

   logic [DIV_W-1:0] w_eff_div;
   logic [3:0]       w_new_len;
   logic             w_bit_last;
   logic             w_frame_last;
   logic             w_launch;

   always_comb begin
      if (div == '0) begin
         w_eff_div = C_DEF;
      end else if (div < C_MIN) begin
         w_eff_div = C_MIN;
      end else begin
         w_eff_div = div;
      end
   end

   assign w_new_len    = frame_len(data_bits, parity_en, stop2);
   assign w_bit_last   = (state_q == S_RUN) && (cnt_q == dvm1_q);
   assign w_frame_last = w_bit_last && (idx_q == last_q);
   // A new frame starts from idle, or seamlessly on the last edge of a frame.
   assign w_launch     = start && !abort && ((state_q == S_IDLE) || w_frame_last);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (w_frame_last && !start) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------ counter and strobes
   always_comb begin
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      dvm1_d = dvm1_q;
      hm1_d  = hm1_q;
      last_d = last_q;
      mid_d  = 1'b0;
      end_d  = 1'b0;
      done_d = 1'b0;

      if (state_q == S_RUN) begin
         if (abort) begin
            cnt_d = '0;
            idx_d = '0;
         end else begin
            mid_d  = (cnt_q == hm1_q);
            end_d  = w_bit_last;
            done_d = w_frame_last;
            if (w_bit_last) begin
               cnt_d = '0;
               idx_d = w_frame_last ? 4'd0 : idx_q + 4'd1;
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
         end
      end

      if (w_launch) begin
         dvm1_d = w_eff_div - C_ONE;
         hm1_d  = (w_eff_div >> 1) - C_ONE;
         last_d = w_new_len - 4'd1;
         cnt_d  = '0;
         idx_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         dvm1_q <= '0;
         hm1_q  <= '0;
         last_q <= '0;
         mid_q  <= 1'b0;
         end_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         dvm1_q <= dvm1_d;
         hm1_q  <= hm1_d;
         last_q <= last_d;
         mid_q  <= mid_d;
         end_q  <= end_d;
         done_q <= done_d;
      end
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      busy       = (state_q == S_RUN);
      bit_mid    = mid_q;
      bit_end    = end_q;
      bit_idx    = idx_q;
      frame_done = done_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_bps_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_bps_gen
// Description : Self-checking bench for uart_bps_gen against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bps_gen;
   import uart_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] div = 16'd0;
   logic [1:0]  data_bits = 2'b00;
   logic        parity_en = 1'b0;
   logic        stop2 = 1'b0;
   logic        busy, bit_mid, bit_end, frame_done;
   logic [3:0]  bit_idx;

   uart_bps_gen #(.DIV_W(16), .DEF_DIV(5208), .MIN_DIV(2)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .div(div),
      .data_bits(data_bits), .parity_en(parity_en), .stop2(stop2),
      .busy(busy), .bit_mid(bit_mid), .bit_end(bit_end),
      .bit_idx(bit_idx), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail   = 0;

   // Reference model: frame described by its start edge, divisor and length.
   longint edge_n = 0;
   bit     m_active = 0;
   longint m_s, m_dv, m_h, m_n;
   longint exp_busy, exp_mid, exp_end, exp_done, exp_idx;

   // Observations for latency checks
   longint obs_first_mid, obs_done_edge, start_edge;
   int     obs_done_cnt;

   task automatic check(input string tag, input longint obs, input longint expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_n, obs, expv);
      end
   endtask

   task automatic model_launch(input logic [15:0] dv_in, input logic [1:0] db,
                               input bit pe, input bit s2);
      m_active = 1;
      m_s      = edge_n;
      if (dv_in == 0)      m_dv = 5208;
      else if (dv_in < 2)  m_dv = 2;
      else                 m_dv = dv_in;
      m_h      = m_dv / 2;
      m_n      = 1 + (5 + db) + pe + (1 + s2);
      exp_busy = 1;
      exp_idx  = 0;
   endtask

   task automatic model_edge(input bit st, input bit ab, input logic [15:0] dv_in,
                             input logic [1:0] db, input bit pe, input bit s2);
      longint e, fl;
      exp_busy = 0; exp_mid = 0; exp_end = 0; exp_done = 0; exp_idx = 0;
      if (m_active) begin
         if (ab) begin
            m_active = 0;
         end else begin
            e  = edge_n - m_s;
            fl = m_n * m_dv;
            exp_mid  = (e >= m_h && ((e - m_h) % m_dv) == 0 && e < fl) ? 1 : 0;
            exp_end  = (e >= m_dv && (e % m_dv) == 0) ? 1 : 0;
            exp_done = (e == fl) ? 1 : 0;
            exp_busy = (e < fl) ? 1 : 0;
            exp_idx  = (e < fl) ? e / m_dv : 0;
            if (e == fl) begin
               m_active = 0;
               if (st) model_launch(dv_in, db, pe, s2);
            end
         end
      end else if (st && !ab) begin
         model_launch(dv_in, db, pe, s2);
      end
   endtask

   task automatic tick();
      bit          st = start;
      bit          ab = abort;
      logic [15:0] dv = div;
      logic [1:0]  db = data_bits;
      bit          pe = parity_en;
      bit          s2 = stop2;
      @(posedge clk);
      edge_n++;
      model_edge(st, ab, dv, db, pe, s2);
      #1;
      check("busy",       busy,       exp_busy);
      check("bit_mid",    bit_mid,    exp_mid);
      check("bit_end",    bit_end,    exp_end);
      check("frame_done", frame_done, exp_done);
      check("bit_idx",    bit_idx,    exp_idx);
      if (bit_mid && obs_first_mid < 0) obs_first_mid = edge_n;
      if (frame_done) begin
         obs_done_edge = edge_n;
         obs_done_cnt++;
      end
   endtask

   task automatic clear_obs();
      obs_first_mid = -1;
      obs_done_edge = -1;
      obs_done_cnt  = 0;
   endtask

   task automatic launch(input logic [15:0] dv, input logic [1:0] db, input bit pe, input bit s2);
      div = dv; data_bits = db; parity_en = pe; stop2 = s2;
      clear_obs();
      start = 1'b1;
      tick();
      start_edge = edge_n;
      start = 1'b0;
   endtask

   task automatic run_idle(input int limit);
      for (int i = 0; i < limit && m_active; i++) tick();
      check("frame_timeout_busy", busy, 0);
   endtask

   task automatic run_to(input longint e_target);
      for (int i = 0; i < 100000 && (edge_n - m_s) < e_target; i++) tick();
   endtask

   initial begin
      clear_obs();
      // Reset state
      #1;
      check("rst_busy", busy, 0);
      check("rst_mid", bit_mid, 0);
      check("rst_end", bit_end, 0);
      check("rst_done", frame_done, 0);
      check("rst_idx", bit_idx, 0);
      @(negedge clk);
      rst = 1'b0;
      tick(); tick();

      // 8N1 at 9600 baud divisor
      launch(16'd5208, DB8, 1'b0, 1'b0);
      run_idle(60000);
      check("lat_first_mid_5208", obs_first_mid - start_edge, 2604);
      check("lat_done_5208", obs_done_edge - start_edge, 52080);

      // 5 data bits, parity, 2 stop
      launch(16'd4, DB5, 1'b1, 1'b1);
      run_idle(100);
      check("lat_first_mid_4", obs_first_mid - start_edge, 2);
      check("lat_done_4", obs_done_edge - start_edge, 36);

      // div=1 clamps to 2; inputs changed mid-frame must not matter
      launch(16'd1, DB8, 1'b0, 1'b0);
      tick(); tick();
      div = 16'd9; data_bits = DB5; parity_en = 1'b1; stop2 = 1'b1;
      run_idle(100);
      check("lat_done_clamp", obs_done_edge - start_edge, 20);

      // div=0 uses the default divisor; abort after the first bit
      launch(16'd0, DB8, 1'b0, 1'b0);
      run_to(5210);
      check("def_div_first_end_idx", bit_idx, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();

      // abort at bit_idx=4, cnt=3 with a simultaneous start
      launch(16'd8, DB8, 1'b0, 1'b0);
      run_to(35);
      check("abort_pre_idx", bit_idx, 4);
      abort = 1'b1; start = 1'b1;
      tick();
      check("abort_busy", busy, 0);
      check("abort_idx", bit_idx, 0);
      tick();
      check("abort_idle_start_ignored", busy, 0);
      abort = 1'b0; start = 1'b0;
      tick(); tick();
      check("abort_no_done", obs_done_cnt, 0);

      // 7E2 back-to-back with start held; second frame relatches new format
      launch(16'd6, DB7, 1'b1, 1'b1);
      start = 1'b1;
      run_to(11 * 6 - 1);
      div = 16'd3; data_bits = DB5; parity_en = 1'b0; stop2 = 1'b0;
      tick();
      check("b2b_done", frame_done, 1);
      check("b2b_busy", busy, 1);
      check("b2b_idx", bit_idx, 0);
      start_edge = edge_n;
      start = 1'b0;
      run_idle(100);
      check("b2b_done_cnt", obs_done_cnt, 2);
      check("b2b_second_len", obs_done_edge - start_edge, 21);

      // Asynchronous reset mid-frame at bit_idx=3
      launch(16'd5, DB6, 1'b0, 1'b0);
      run_to(17);
      check("pre_rst_idx", bit_idx, 3);
      #2;
      rst = 1'b1;
      #1;
      m_active = 0;
      check("arst_busy", busy, 0);
      check("arst_idx", bit_idx, 0);
      check("arst_mid", bit_mid, 0);
      check("arst_end", bit_end, 0);
      check("arst_done", frame_done, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) tick();

      // Randomized stimulus: short divisors, random formats, starts and aborts
      for (int i = 0; i < 4000; i++) begin
         div       = 16'($urandom_range(1, 12));
         data_bits = 2'($urandom_range(0, 3));
         parity_en = 1'($urandom_range(0, 1));
         stop2     = 1'($urandom_range(0, 1));
         start     = ($urandom_range(0, 7) == 0);
         abort     = ($urandom_range(0, 99) == 0);
         tick();
      end
      start = 1'b0; abort = 1'b0;
      run_idle(400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_bps_gen.md
Name: uart_bps_gen

Overview:
Parametrised UART bit-timing generator, successor to the fixed 8N1 TX baud divider. It provides a runtime-programmable divisor and frame format: 5–8 data bits, optional parity, 1 or 2 stop bits. It issues per-bit mid-point and end-of-bit strobes, a bit index and an end-of-frame pulse. It sits between the UART TX/RX datapaths and the register block, so one instance can drive either shifter.

Parameters:
DIV_W, 16, width of divisor input and internal bit counter
DEF_DIV, 5208, divisor used when div input is 0 (50 MHz / 9600)
MIN_DIV, 2, smallest effective divisor; latched values 1..MIN_DIV-1 clamp to MIN_DIV

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  asynchronous, active-high reset
start  in  1  request new frame; sampled on the clk rising edge
abort  in  1  terminate the current frame immediately; priority over start
div  in  DIV_W  clocks per bit; latched at frame start
data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits; latched at frame start
parity_en  in  1  adds one parity bit slot; latched at frame start
stop2  in  1  0=1 stop bit, 1=2 stop bits; latched at frame start
busy  out  1  frame in progress
bit_mid  out  1  one-cycle strobe at the middle of each bit (sample/shift point)
bit_end  out  1  one-cycle strobe at the end of each bit
bit_idx  out  4  current bit slot: 0=start, 1..D=data, then parity, then stop
frame_done  out  1  one-cycle strobe coincident with the final bit_end

Behaviour:
- Reset (async, rst=1): busy, bit_mid, bit_end, frame_done, bit_idx and counter all 0; state IDLE. Reset mid-frame abandons the frame with no frame_done.
- Frame length N = 1 + (5+data_bits) + parity_en + (1+stop2). Range 7..12.
- Effective divisor Dv:
  - DEF_DIV if div==0.
  - MIN_DIV if 0<div<MIN_DIV.
  - Otherwise div.
  - Half point H = Dv>>1 (floor).
- States IDLE and RUN.
  - IDLE: on start=1 and abort=0, latch Dv, N, format. Go to RUN with cnt=0, bit_idx=0, busy=1, all effective the edge start is sampled.
  - RUN: cnt counts 0..Dv-1 and wraps.
- Strobes are registered and one cycle wide.
  - bit_mid is high in the cycle after cnt==H-1.
  - bit_end is high in the cycle after cnt==Dv-1.
- On the edge where cnt==Dv-1:
  - If bit_idx<N-1: bit_idx increments. The updated value is visible in the same cycle bit_end is high.
  - If bit_idx==N-1: bit_end=1, frame_done=1, bit_idx=0, busy=0, state IDLE.
- Back-to-back frames: start=1 on the final edge (cnt==Dv-1, bit_idx==N-1) relatches the parameters and stays in RUN with busy=1 and cnt=0, with no idle cycle. frame_done still pulses.
- start while RUN (other than the final edge) is ignored. Latched div and format are immune to input changes mid-frame.
- abort=1 in RUN: next edge forces IDLE, cnt=0, bit_idx=0, busy=0. No bit_mid, bit_end or frame_done is generated on that edge. abort in IDLE has no effect, and start is ignored in that cycle.
- Latency from start edge:
  - First bit_mid visible after H edges.
  - Each bit_end visible k*Dv edges after start (k=1..N).
  - frame_done visible N*Dv edges after start.
- Counter width is DIV_W with no overflow. The compare uses latched Dv-1, computed as unsigned DIV_W bits.

Decomposition:
- Shared package uart_pkg holds:
  - Data-bit encoding constants DB5..DB8.
  - Bit-slot limits (MAX_FRAME_BITS=12).
  - Function frame_len(data_bits, parity_en, stop2) returning 4 bits, reused by the TX/RX shifters.
  - DEF_DIV and MIN_DIV defaults.
- No sub-module: the counter, state register and strobe decode are a single tightly coupled unit and stay flat.

Test Plan:
- Reset, then div=5208, data_bits=11, parity_en=0, stop2=0, pulse start: N=10, first bit_mid 2604 cycles after start edge, bit_end every 5208, frame_done 52080 cycles after, busy low same cycle.
- div=4, data_bits=00, parity_en=1, stop2=1: N=9, bit_mid at cycles 2,6,...,34, frame_done at cycle 36, bit_idx sequence 0..8 then 0.
- div=1 then div=0: Dv clamps to 2 (frame 10 bits = 20 cycles), then DEF_DIV used (52080 cycles); change div mid-frame with no effect on the current frame.
- div=8, 8N1, abort asserted at bit_idx=4, cnt=3: busy=0, bit_idx=0 next cycle, no frame_done; start with abort same cycle is ignored.
- div=6, 7E2 with start held on the final edge: frame_done pulses, busy stays 1, next frame bit_idx=0, cnt=0 with no gap; second frame uses inputs relatched at that edge.
- Assert rst at bit_idx=3 mid-frame: all outputs 0 immediately (asynchronous); after release, the block stays idle until start.
